// File: rtl/riscvx_pkg.sv
// rtl/riscvx_pkg.sv - shared types and constants for the pipeline hazard controller
package riscvx_pkg;

  // Controller FSM: normal flow, or parked behind a slow data-memory access
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_e;

  // Default number of MEM_WAIT cycles tolerated before reporting mem_err
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

  // Width of the memory wait counter
  localparam int unsigned WAIT_CNT_W = 16;

  // Width of each performance counter
  localparam int unsigned PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - stall/flush/load-use performance counters (built only with PIPELINE_PERF_CNT_EN)
`ifdef PIPELINE_PERF_CNT_EN
module pipe_perf_cnt
  import riscvx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_ev,
  input  logic                  flush_ev,
  input  logic                  lu_ev,
  output logic [PERF_CNT_W-1:0] perf_stall,
  output logic [PERF_CNT_W-1:0] perf_flush,
  output logic [PERF_CNT_W-1:0] perf_lu
);

  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PERF_CNT_W-1:0] lu_cnt_q,    lu_cnt_d;

  // Each counter bumps once per event cycle and wraps naturally at the top
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    lu_cnt_d    = lu_cnt_q;
    if (stall_ev) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_ev) flush_cnt_d = flush_cnt_q + 1'b1;
    if (lu_ev)    lu_cnt_d    = lu_cnt_q + 1'b1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign perf_stall = stall_cnt_q;
  assign perf_flush = flush_cnt_q;
  assign perf_lu    = lu_cnt_q;

endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline stall/flush controller; optional counters via PIPELINE_PERF_CNT_EN
module pipeline_ctrl
  import riscvx_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memread_EX,
  input  logic [4:0]            rd_EX,
  input  logic [4:0]            rs1_ID,
  input  logic [4:0]            rs2_ID,
  input  logic                  use_rs1_ID,
  input  logic                  use_rs2_ID,
  input  logic                  redirect_EX,
  input  logic                  dmem_req_MEM,
  input  logic                  dmem_ready,
  output logic                  stall_IF,
  output logic                  flush_IFID,
  output logic                  stall_IDEX,
  output logic                  flush_IDEX,
  output logic                  stall_EXMEM,
  output logic                  mem_err,
  output logic [PERF_CNT_W-1:0] perf_stall,
  output logic [PERF_CNT_W-1:0] perf_flush,
  output logic [PERF_CNT_W-1:0] perf_lu
);

  // Counter value seen in the last MEM_WAIT cycle before giving up
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  pipe_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic rs1_hit, rs2_hit;
  logic load_use;
  logic mem_busy;
  logic timeout;

  logic stall_if_c, flush_ifid_c, stall_idex_c, flush_idex_c, stall_exmem_c, mem_err_c;

  // Hazard detection: x0 never carries a real dependency
  assign rs1_hit  = use_rs1_ID & (rs1_ID == rd_EX);
  assign rs2_hit  = use_rs2_ID & (rs2_ID == rd_EX);
  assign load_use = memread_EX & (rd_EX != 5'd0) & (rs1_hit | rs2_hit);
  assign mem_busy = dmem_req_MEM & ~dmem_ready;

  // Give up on a memory access that has sat in MEM_WAIT too long
  assign timeout  = (state_q == MEM_WAIT) && mem_busy && (wait_cnt_q == TIMEOUT_CNT);

  // Next state and hazard outputs; memory stall outranks redirect, which outranks load-use
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    stall_if_c    = 1'b0;
    flush_ifid_c  = 1'b0;
    stall_idex_c  = 1'b0;
    flush_idex_c  = 1'b0;
    stall_exmem_c = 1'b0;
    mem_err_c     = 1'b0;

    if (timeout) begin
      // Release the whole pipe and flag the error; the wait is abandoned
      mem_err_c  = 1'b1;
      state_d    = RUN;
      wait_cnt_d = '0;
    end else if (mem_busy) begin
      // Freeze everything upstream of MEM; redirect/load-use stay pending in place
      stall_if_c    = 1'b1;
      stall_idex_c  = 1'b1;
      stall_exmem_c = 1'b1;
      if (state_q == RUN) begin
        state_d    = MEM_WAIT;
        wait_cnt_d = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else begin
      // Memory is free this cycle, so stalls release with no extra latency
      state_d    = RUN;
      wait_cnt_d = '0;
      if (redirect_EX) begin
        // ID holds a wrong-path instruction, so its load-use hazard is moot
        flush_ifid_c = 1'b1;
        flush_idex_c = 1'b1;
      end else if (load_use) begin
        // Hold IF/ID one cycle and inject a bubble into EX
        stall_if_c   = 1'b1;
        flush_idex_c = 1'b1;
      end
    end
  end

  // State and wait counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // All control outputs are held low while reset is asserted
  assign stall_IF    = reset & stall_if_c;
  assign flush_IFID  = reset & flush_ifid_c;
  assign stall_IDEX  = reset & stall_idex_c;
  assign flush_IDEX  = reset & flush_idex_c;
  assign stall_EXMEM = reset & stall_exmem_c;
  assign mem_err     = reset & mem_err_c;

`ifdef PIPELINE_PERF_CNT_EN
  // Load-use bubble is the only case that stalls IF while bubbling EX
  pipe_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .stall_ev   (stall_IF),
    .flush_ev   (flush_IFID),
    .lu_ev      (stall_IF & flush_IDEX),
    .perf_stall (perf_stall),
    .perf_flush (perf_flush),
    .perf_lu    (perf_lu)
  );
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
  assign perf_lu    = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
`timescale 1ns/1ps
module tb_pipeline_ctrl;
  import riscvx_pkg::*;

`ifdef PIPELINE_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  // Output vector order: {stall_IF, flush_IFID, stall_IDEX, flush_IDEX, stall_EXMEM, mem_err}
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b100100;
  localparam logic [5:0] O_RDIR = 6'b010100;
  localparam logic [5:0] O_MEM  = 6'b101010;
  localparam logic [5:0] O_ERR  = 6'b000001;

  logic        clk;
  logic        reset;
  logic        memread_EX;
  logic [4:0]  rd_EX, rs1_ID, rs2_ID;
  logic        use_rs1_ID, use_rs2_ID;
  logic        redirect_EX;
  logic        dmem_req_MEM, dmem_ready;
  logic        stall_IF, flush_IFID, stall_IDEX, flush_IDEX, stall_EXMEM, mem_err;
  logic [31:0] perf_stall, perf_flush, perf_lu;
  logic [5:0]  outs;

  int tests_run;
  int tests_failed;
  int exp_stall, exp_flush, exp_lu;

  assign outs = {stall_IF, flush_IFID, stall_IDEX, flush_IDEX, stall_EXMEM, mem_err};

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .memread_EX   (memread_EX),
    .rd_EX        (rd_EX),
    .rs1_ID       (rs1_ID),
    .rs2_ID       (rs2_ID),
    .use_rs1_ID   (use_rs1_ID),
    .use_rs2_ID   (use_rs2_ID),
    .redirect_EX  (redirect_EX),
    .dmem_req_MEM (dmem_req_MEM),
    .dmem_ready   (dmem_ready),
    .stall_IF     (stall_IF),
    .flush_IFID   (flush_IFID),
    .stall_IDEX   (stall_IDEX),
    .flush_IDEX   (flush_IDEX),
    .stall_EXMEM  (stall_EXMEM),
    .mem_err      (mem_err),
    .perf_stall   (perf_stall),
    .perf_flush   (perf_flush),
    .perf_lu      (perf_lu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    memread_EX   = 1'b0;
    rd_EX        = 5'd0;
    rs1_ID       = 5'd0;
    rs2_ID       = 5'd0;
    use_rs1_ID   = 1'b0;
    use_rs2_ID   = 1'b0;
    redirect_EX  = 1'b0;
    dmem_req_MEM = 1'b0;
    dmem_ready   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    // A live load-use hazard must not leak through while in reset
    memread_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; use_rs1_ID = 1'b1;
    #3;
    tests_run++;
    if (outs !== O_IDLE) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected %b", outs, O_IDLE);
    end
    cyc(); #2;
    tests_run++;
    if (dut.state_q !== RUN) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected %0d", dut.state_q, RUN);
    end
    tests_run++;
    if ({perf_stall, perf_flush, perf_lu} !== 96'd0) begin
      tests_failed++;
      $display("FAIL reset_perf: got %0d/%0d/%0d expected 0/0/0", perf_stall, perf_flush, perf_lu);
    end
    clear_inputs();
    reset = 1'b1;
    cyc(); #2;
    tests_run++;
    if (outs !== O_IDLE) begin
      tests_failed++;
      $display("FAIL idle_outputs: got %b expected %b", outs, O_IDLE);
    end
  endtask

  task automatic test_load_use();
    // rs1 dependency on a load
    cyc();
    memread_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; use_rs1_ID = 1'b1;
    #2;
    tests_run++;
    if (outs !== O_LU) begin
      tests_failed++;
      $display("FAIL load_use_rs1: got %b expected %b", outs, O_LU);
    end
    exp_stall++; exp_lu++;
    // Bubble now in EX: no load there, so no repeat stall
    cyc();
    memread_EX = 1'b0;
    #2;
    tests_run++;
    if (outs !== O_IDLE) begin
      tests_failed++;
      $display("FAIL load_use_bubble: got %b expected %b", outs, O_IDLE);
    end
    tests_run++;
    if (perf_lu !== (PERF_ON ? 32'(exp_lu) : 32'd0)) begin
      tests_failed++;
      $display("FAIL perf_lu_after_one: got %0d expected %0d", perf_lu, PERF_ON ? exp_lu : 0);
    end
    // rs2 dependency
    cyc();
    clear_inputs();
    memread_EX = 1'b1; rd_EX = 5'd7; rs2_ID = 5'd7; use_rs2_ID = 1'b1; rs1_ID = 5'd3; use_rs1_ID = 1'b1;
    #2;
    tests_run++;
    if (outs !== O_LU) begin
      tests_failed++;
      $display("FAIL load_use_rs2: got %b expected %b", outs, O_LU);
    end
    exp_stall++; exp_lu++;
    // Matching register that is not actually read
    cyc();
    use_rs2_ID = 1'b0;
    #2;
    tests_run++;
    if (outs !== O_IDLE) begin
      tests_failed++;
      $display("FAIL load_use_unused_src: got %b expected %b", outs, O_IDLE);
    end
    // x0 destination never creates a hazard
    cyc();
    clear_inputs();
    memread_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0; use_rs1_ID = 1'b1;
    #2;
    tests_run++;
    if (outs !== O_IDLE) begin
      tests_failed++;
      $display("FAIL load_use_rd_zero: got %b expected %b", outs, O_IDLE);
    end
    cyc();
    clear_inputs();
  endtask

  task automatic test_back_to_back_redirect();
    // Two redirects in a row, the second alongside a load-use hazard
    for (int i = 0; i < 2; i++) begin
      cyc();
      clear_inputs();
      redirect_EX = 1'b1;
      if (i == 1) begin
        memread_EX = 1'b1; rd_EX = 5'd9; rs1_ID = 5'd9; use_rs1_ID = 1'b1;
      end
      #2;
      tests_run++;
      if (outs !== O_RDIR) begin
        tests_failed++;
        $display("FAIL redirect_%0d: got %b expected %b", i, outs, O_RDIR);
      end
      exp_flush++;
    end
    cyc();
    clear_inputs();
    #2;
    tests_run++;
    if (outs !== O_IDLE) begin
      tests_failed++;
      $display("FAIL redirect_release: got %b expected %b", outs, O_IDLE);
    end
    tests_run++;
    if (perf_flush !== (PERF_ON ? 32'(exp_flush) : 32'd0)) begin
      tests_failed++;
      $display("FAIL perf_flush: got %0d expected %0d", perf_flush, PERF_ON ? exp_flush : 0);
    end
  endtask

  task automatic test_mem_wait();
    logic [5:0] exp_tab [4];
    exp_tab = '{O_MEM, O_MEM, O_MEM, O_IDLE};
    for (int i = 0; i < 4; i++) begin
      cyc();
      dmem_req_MEM = 1'b1;
      dmem_ready   = (i == 3);
      #2;
      tests_run++;
      if (outs !== exp_tab[i]) begin
        tests_failed++;
        $display("FAIL mem_wait_cycle%0d: got %b expected %b", i, outs, exp_tab[i]);
      end
      if (i == 1) begin
        tests_run++;
        if (dut.state_q !== MEM_WAIT) begin
          tests_failed++;
          $display("FAIL mem_wait_state: got %0d expected %0d", dut.state_q, MEM_WAIT);
        end
      end
    end
    exp_stall += 3;
    cyc();
    clear_inputs();
    #2;
    tests_run++;
    if (dut.state_q !== RUN) begin
      tests_failed++;
      $display("FAIL mem_wait_back_to_run: got %0d expected %0d", dut.state_q, RUN);
    end
    tests_run++;
    if (perf_stall !== (PERF_ON ? 32'(exp_stall) : 32'd0)) begin
      tests_failed++;
      $display("FAIL perf_stall: got %0d expected %0d", perf_stall, PERF_ON ? exp_stall : 0);
    end
  endtask

  task automatic test_priority_mem_redirect();
    logic [5:0] exp_tab [4];
    exp_tab = '{O_MEM, O_MEM, O_RDIR, O_IDLE};
    for (int i = 0; i < 4; i++) begin
      cyc();
      clear_inputs();
      if (i < 3) begin
        dmem_req_MEM = 1'b1;
        dmem_ready   = (i == 2);
        redirect_EX  = 1'b1;
        memread_EX = 1'b1; rd_EX = 5'd4; rs2_ID = 5'd4; use_rs2_ID = 1'b1;
      end
      #2;
      tests_run++;
      if (outs !== exp_tab[i]) begin
        tests_failed++;
        $display("FAIL prio_mem_redirect_cycle%0d: got %b expected %b", i, outs, exp_tab[i]);
      end
    end
    exp_stall += 2;
    exp_flush += 1;
  endtask

  task automatic test_timeout();
    // MEM_TIMEOUT=4: the 4th MEM_WAIT cycle (5th busy cycle) reports the error
    logic [5:0] exp_tab [7];
    exp_tab = '{O_MEM, O_MEM, O_MEM, O_MEM, O_ERR, O_MEM, O_IDLE};
    for (int i = 0; i < 7; i++) begin
      cyc();
      clear_inputs();
      dmem_req_MEM = (i < 6);
      #2;
      tests_run++;
      if (outs !== exp_tab[i]) begin
        tests_failed++;
        $display("FAIL timeout_cycle%0d: got %b expected %b", i, outs, exp_tab[i]);
      end
    end
    exp_stall += 5;
    tests_run++;
    if ({perf_stall, perf_flush, perf_lu} !==
        (PERF_ON ? {32'(exp_stall), 32'(exp_flush), 32'(exp_lu)} : 96'd0)) begin
      tests_failed++;
      $display("FAIL perf_totals: got %0d/%0d/%0d expected %0d/%0d/%0d",
               perf_stall, perf_flush, perf_lu,
               PERF_ON ? exp_stall : 0, PERF_ON ? exp_flush : 0, PERF_ON ? exp_lu : 0);
    end
    cyc();
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    cyc();
    dmem_req_MEM = 1'b1;
    cyc();
    // Second MEM_WAIT cycle: assert reset with the request still pending
    cyc();
    reset = 1'b0;
    #2;
    exp_stall = 0; exp_flush = 0; exp_lu = 0;
    tests_run++;
    if (outs !== O_IDLE) begin
      tests_failed++;
      $display("FAIL reset_mid_wait_outputs: got %b expected %b", outs, O_IDLE);
    end
    tests_run++;
    if (dut.state_q !== RUN) begin
      tests_failed++;
      $display("FAIL reset_mid_wait_state: got %0d expected %0d", dut.state_q, RUN);
    end
    tests_run++;
    if ({perf_stall, perf_flush, perf_lu} !== 96'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_wait_perf: got %0d/%0d/%0d expected 0/0/0", perf_stall, perf_flush, perf_lu);
    end
    // Stay in reset across the old timeout point: still no error
    for (int i = 0; i < 4; i++) begin
      cyc();
      tests_run++;
      if (mem_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_wait_no_err%0d: got %b expected 0", i, mem_err);
      end
    end
    clear_inputs();
    reset = 1'b1;
    cyc();
    #2;
    tests_run++;
    if (outs !== O_IDLE) begin
      tests_failed++;
      $display("FAIL after_reset_idle: got %b expected %b", outs, O_IDLE);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_stall    = 0;
    exp_flush    = 0;
    exp_lu       = 0;
    test_reset();
    test_load_use();
    test_back_to_back_redirect();
    test_mem_wait();
    test_priority_mem_redirect();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
